alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 124 ++++++++++++
 tb/tb_alu_result_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//
// Show-ahead FIFO that holds ALU results together with their overflow flag,
// plus a sticky overflow indicator for software to poll and clear.
//
// Optional feature: define ALU_RESULT_BUFFER_OVF_CNT_EN to add a 16-bit
// saturating counter (ovf_cnt) of accepted entries that carried overflow.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst          - asynchronous, active-low reset
//   in_valid     - producer has a result this cycle
//   in_result    - signed ALU result (DATA_W bits)
//   in_overflow  - overflow flag belonging to in_result
//   in_ready     - buffer has room (registered occupancy != DEPTH)
//   out_valid    - head entry present (registered occupancy != 0)
//   out_result   - head entry result, 0 when empty
//   out_overflow - head entry overflow flag, 0 when empty
//   out_ready    - consumer takes the head entry this cycle
//   count        - current occupancy, 0..DEPTH
//   sticky_ovf   - set once any accepted entry had overflow
//   ovf_cnt      - (optional) saturating count of accepted overflow entries
//   clr_sticky   - synchronous clear of sticky_ovf (and ovf_cnt)
// ---------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_overflow,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_overflow,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
  output logic [15:0]              ovf_cnt,
`endif
  input  logic                     clr_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // Each entry stores {result, overflow} so both leave the buffer together.
  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [DATA_W:0]    head;

  // Handshakes are qualified only by registered occupancy, so a pop on a
  // full cycle never frees a slot for a same-cycle push.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is read straight from storage; gating with out_valid hides stale
  // contents while empty.
  assign head         = mem[rd_ptr];
  assign out_result   = out_valid ? head[DATA_W:1] : '0;
  assign out_overflow = out_valid & head[0];

  // Storage is not reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_result, in_overflow};
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new overflow outranks a clear issued in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_ovf <= 1'b0;
    end else if (push && in_overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
  // Unlike the sticky bit, the counter lets the clear win over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (clr_sticky) begin
      ovf_cnt <= '0;
    end else if (push && in_overflow && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Directed testbench for alu_result_buffer (DEPTH=8, DATA_W=32). Honours
// ALU_RESULT_BUFFER_OVF_CNT_EN when defined to also check ovf_cnt.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_ready;
  logic [3:0]  count;
  logic        sticky_ovf;
  logic        clr_sticky;
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int checks;
  int failures;

  alu_result_buffer #(.DEPTH(8), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_ready    (out_ready),
    .count        (count),
    .sticky_ovf   (sticky_ovf),
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
    .ovf_cnt      (ovf_cnt),
`endif
    .clr_sticky   (clr_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (count !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    checks++;
    if (sticky_ovf !== 1'b0 || out_result !== 32'd0 || out_overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_outputs got sticky=%b res=%h ovf=%b exp 0/0/0", sticky_ovf, out_result, out_overflow);
    end
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_ovf_cnt got=%0d exp=0", ovf_cnt);
    end
`endif
    rst = 1'b1;
  endtask

  // Three pushes while the consumer stalls, then an in-order drain.
  task automatic test_basic();
    logic [31:0] exp_res [3];
    logic        exp_ovf [3];
    exp_res[0] = 32'd25;         exp_ovf[0] = 1'b0;
    exp_res[1] = 32'd15;         exp_ovf[1] = 1'b0;
    exp_res[2] = 32'h8000_0000;  exp_ovf[2] = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = exp_res[i]; in_overflow = exp_ovf[i];
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("[TB] FAIL no_fall_through got out_valid=%b exp=0", out_valid);
        end
      end
      step();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd25) begin
          failures++; $display("[TB] FAIL first_push got valid=%b res=%0d exp 1/25", out_valid, out_result);
        end
      end
    end
    in_valid = 1'b0; in_overflow = 1'b0;
    checks++;
    if (count !== 4'd3 || sticky_ovf !== 1'b1) begin
      failures++; $display("[TB] FAIL basic_fill got count=%0d sticky=%b exp 3/1", count, sticky_ovf);
    end
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd1) begin
      failures++; $display("[TB] FAIL basic_ovf_cnt got=%0d exp=1", ovf_cnt);
    end
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp_res[i] || out_overflow !== exp_ovf[i]) begin
        failures++; $display("[TB] FAIL basic_pop%0d got v=%b res=%h ovf=%b exp 1/%h/%b", i, out_valid, out_result, out_overflow, exp_res[i], exp_ovf[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_result !== 32'd0) begin
      failures++; $display("[TB] FAIL basic_empty got count=%0d v=%b res=%h exp 0/0/0", count, out_valid, out_result);
    end
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_clr_sticky got=%b exp=0", sticky_ovf);
    end
  endtask

  // Fill to DEPTH, try an extra push, drain everything.
  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_result = 32'd100 + 32'(i); in_overflow = 1'b0;
      step();
    end
    checks++;
    if (in_ready !== 1'b0 || count !== 4'd8) begin
      failures++; $display("[TB] FAIL full_flags got in_ready=%b count=%0d exp 0/8", in_ready, count);
    end
    in_result = 32'd999;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd8 || out_result !== 32'd100) begin
      failures++; $display("[TB] FAIL full_ignore got count=%0d head=%0d exp 8/100", count, out_result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd100 + 32'(i)) begin
        failures++; $display("[TB] FAIL full_drain%0d got v=%b res=%0d exp 1/%0d", i, out_valid, out_result, 100 + i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL full_empty got count=%0d v=%b exp 0/0", count, out_valid);
    end
  endtask

  // Push and pop together while full: only the pop happens.
  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_result = 32'd200 + 32'(i); in_overflow = 1'b0;
      step();
    end
    in_result = 32'd777;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd7 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL full_pushpop got count=%0d in_ready=%b exp 7/1", count, in_ready);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd200 + 32'(i)) begin
        failures++; $display("[TB] FAIL full_pushpop_drain%0d got v=%b res=%0d exp 1/%0d", i, out_valid, out_result, 200 + i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      failures++; $display("[TB] FAIL full_pushpop_empty got count=%0d exp 0", count);
    end
  endtask

  // Steady streaming at occupancy 3 across several pointer wraps.
  task automatic test_back_to_back();
    logic [31:0] v [23];
    v[0] = 32'hFFFF_FFE8;   // -24
    v[1] = 32'd200;
    v[2] = 32'd123;
    for (int k = 3; k < 23; k++) begin
      v[k] = 32'(k * 37) - 32'd100;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_result = v[k]; in_overflow = 1'b0;
      step();
    end
    for (int k = 3; k < 23; k++) begin
      in_valid = 1'b1; in_result = v[k]; out_ready = 1'b1;
      checks++;
      if (out_result !== v[k-3]) begin
        failures++; $display("[TB] FAIL stream_head%0d got=%h exp=%h", k, out_result, v[k-3]);
      end
      step();
      checks++;
      if (count !== 4'd3) begin
        failures++; $display("[TB] FAIL stream_count%0d got=%0d exp=3", k, count);
      end
    end
    in_valid = 1'b0;
    for (int k = 20; k < 23; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== v[k]) begin
        failures++; $display("[TB] FAIL stream_tail%0d got v=%b res=%h exp 1/%h", k, out_valid, out_result, v[k]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      failures++; $display("[TB] FAIL stream_empty got count=%0d exp 0", count);
    end
  endtask

  // Overflow push with a simultaneous clear, then clear alone.
  task automatic test_sticky_clear();
    in_valid = 1'b1; in_result = 32'h7FFF_FFFF; in_overflow = 1'b1;
    clr_sticky = 1'b1;
    step();
    in_valid = 1'b0; in_overflow = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b1) begin
      failures++; $display("[TB] FAIL sticky_set_wins got=%b exp=1", sticky_ovf);
    end
`ifdef ALU_RESULT_BUFFER_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL ovf_cnt_clear_wins got=%0d exp=0", ovf_cnt);
    end
`endif
    step();
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      failures++; $display("[TB] FAIL sticky_clear got=%b exp=0", sticky_ovf);
    end
    checks++;
    if (out_overflow !== 1'b1 || out_result !== 32'h7FFF_FFFF) begin
      failures++; $display("[TB] FAIL sticky_entry got res=%h ovf=%b exp 7fffffff/1", out_result, out_overflow);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Asynchronous reset in the middle of a drain, then normal recovery.
  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_result = 32'd50 + 32'(i); in_overflow = 1'b1;
      step();
    end
    in_valid = 1'b0; in_overflow = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (count !== 4'd5) begin
      failures++; $display("[TB] FAIL midrst_pre got count=%0d exp=5", count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1 || sticky_ovf !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_async got v=%b count=%0d in_ready=%b sticky=%b exp 0/0/1/0", out_valid, count, in_ready, sticky_ovf);
    end
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    in_valid = 1'b1; in_result = 32'd42; in_overflow = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd42 || count !== 4'd1) begin
      failures++; $display("[TB] FAIL midrst_push got v=%b res=%0d count=%0d exp 1/42/1", out_valid, out_result, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_pop got count=%0d v=%b exp 0/0", count, out_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    in_overflow = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_back_to_back();
    test_sticky_clear();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
